// File: rtl/cpu_pkg.sv
// Purpose: shared types and constants for the instruction fetch path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int ADDR_W = 64;
    localparam int INST_W = 32;
    localparam logic [ADDR_W-1:0] RESET_PC = '0;

    // One fetched instruction together with the address it came from
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Purpose: small FIFO of fetch entries sitting between fetch and decode, with flush.
// Latency: a pushed entry is visible at the head on the cycle after the push.
// Backpressure: the caller must not push when full unless it pops in the same cycle; flush wins over push/pop.
module fetch_buffer
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  fetch_entry_t               din,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       valid,
    output fetch_entry_t               head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    assign head  = mem[rd_ptr];
    assign valid = (count != '0);

    // Storage, pointers and occupancy; entries are zeroed on reset so the head reads 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Purpose: owns the PC, fetches from instruction memory and hands {pc, inst} to decode.
// Latency: an instruction appears at Fetch_Valid one cycle after its address is driven; 1 instr/cycle sustained.
// Backpressure: Fetch_Ready low fills the 2-entry buffer, then the PC holds; branches flush and redirect.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W    = cpu_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC  = cpu_pkg::RESET_PC,
    parameter int                MEM_BYTES = 64,
    parameter int                BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              Fetch_Enable,
    output logic [ADDR_W-1:0] Inst_Address,
    input  logic [31:0]       Instruction,
    input  logic              Branch_Taken,
    input  logic [ADDR_W-1:0] Branch_Target,
    output logic              Fetch_Valid,
    input  logic              Fetch_Ready,
    output logic [31:0]       Fetch_Inst,
    output logic [ADDR_W-1:0] Fetch_PC,
    output logic              Fetch_Error,
    output logic [1:0]        Fetch_Count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 4);
    localparam logic [1:0]        FULL_CNT  = 2'(BUF_DEPTH);

    logic [ADDR_W-1:0] pc_q;
    logic              err_q;
    logic              pop_req;
    logic              buf_pop;
    logic              attempt;
    logic              fault;
    logic              push;
    fetch_entry_t      din;
    fetch_entry_t      head;

    // Memory address comes straight from the PC register, never from an input
    assign Inst_Address = pc_q;
    assign Fetch_Error  = err_q;

    // A decode handshake frees a slot this cycle; a branch discards it instead
    assign pop_req = Fetch_Valid & Fetch_Ready;
    assign buf_pop = pop_req & ~Branch_Taken;

    // A fetch is attempted whenever there is room; the fault check only matters then
    assign attempt = Fetch_Enable & ~err_q & ~Branch_Taken & ((Fetch_Count < FULL_CNT) | pop_req);
    assign fault   = (pc_q[1:0] != 2'b00) | (pc_q > LAST_ADDR);
    assign push    = attempt & ~fault;

    assign din.pc   = pc_q;
    assign din.inst = Instruction;

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_fetch_buffer (
        .clk   (clk),
        .rst_n (reset_n),
        .push  (push),
        .pop   (buf_pop),
        .flush (Branch_Taken),
        .din   (din),
        .count (Fetch_Count),
        .valid (Fetch_Valid),
        .head  (head)
    );

    assign Fetch_Inst = head.inst;
    assign Fetch_PC   = head.pc;

    // PC advance/redirect and the sticky fault flag; a branch always redirects, even after a fault
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q  <= RESET_PC;
            err_q <= 1'b0;
        end else begin
            if (Branch_Taken) begin
                pc_q <= Branch_Target;
            end else if (push) begin
                pc_q <= pc_q + ADDR_W'(4);
            end
            if (attempt && fault) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Purpose: randomized scoreboard bench for instr_fetch_unit against a queue-based reference model.
// Latency: model predicts each entry one cycle after its fetch; monitor compares at the negedge.
// Backpressure: random Fetch_Ready/Fetch_Enable/Branch_Taken plus directed boundary phases.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        Fetch_Enable;
    logic [63:0] Inst_Address;
    logic [31:0] Instruction;
    logic        Branch_Taken;
    logic [63:0] Branch_Target;
    logic        Fetch_Valid;
    logic        Fetch_Ready;
    logic [31:0] Fetch_Inst;
    logic [63:0] Fetch_PC;
    logic        Fetch_Error;
    logic [1:0]  Fetch_Count;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .Fetch_Enable  (Fetch_Enable),
        .Inst_Address  (Inst_Address),
        .Instruction   (Instruction),
        .Branch_Taken  (Branch_Taken),
        .Branch_Target (Branch_Target),
        .Fetch_Valid   (Fetch_Valid),
        .Fetch_Ready   (Fetch_Ready),
        .Fetch_Inst    (Fetch_Inst),
        .Fetch_PC      (Fetch_PC),
        .Fetch_Error   (Fetch_Error),
        .Fetch_Count   (Fetch_Count)
    );

    // Instruction memory: 16 words, combinational read, garbage outside the legal range
    logic [31:0] imem [16];

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a < 64'd64 && a[1:0] == 2'b00) return imem[a[5:2]];
        return 32'hBAD0_BAD0;
    endfunction

    always_comb Instruction = mem_word(Inst_Address);

    // Reference model: the buffer is a queue of expected {pc, inst}; PC and error are plain variables
    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] m_pc;
    bit          m_err;
    bit          chk_en;
    bit          pop_seen;
    int          tests;
    int          fails;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: compares DUT state mid-cycle and retires an entry on each decode handshake
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && reset_n) begin
                check("inst_address", Inst_Address, m_pc);
                check("fetch_error", 64'(Fetch_Error), 64'(m_err));
                check("fetch_count", 64'(Fetch_Count), 64'(exp_q.size()));
                check("fetch_valid", 64'(Fetch_Valid), 64'(exp_q.size() != 0));
                if (exp_q.size() > 0 && Fetch_Ready && !Branch_Taken) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("pop_pc", Fetch_PC, e.pc);
                    check("pop_inst", 64'(Fetch_Inst), 64'(e.inst));
                    pop_seen = 1'b1;
                end else if (exp_q.size() > 0) begin
                    check("head_pc", Fetch_PC, exp_q[0].pc);
                    check("head_inst", 64'(Fetch_Inst), 64'(exp_q[0].inst));
                end
            end
        end
    end

    // Model of one clock edge, from the inputs held during the cycle that just ended
    task automatic model_edge();
        int  occ;
        occ = exp_q.size() + (pop_seen ? 1 : 0);
        if (Branch_Taken) begin
            exp_q.delete();
            m_pc = Branch_Target;
        end else if (Fetch_Enable && !m_err && (occ < 2 || pop_seen)) begin
            if (m_pc[1:0] != 2'b00 || m_pc > 64'd60) begin
                m_err = 1'b1;
            end else begin
                exp_q.push_back('{pc: m_pc, inst: mem_word(m_pc)});
                m_pc = m_pc + 64'd4;
            end
        end
        pop_seen = 1'b0;
    endtask

    // Drive one cycle of stimulus (called just after a rising edge)
    task automatic step(input bit en, input bit rdy, input bit br, input logic [63:0] tgt);
        Fetch_Enable  = en;
        Fetch_Ready   = rdy;
        Branch_Taken  = br;
        Branch_Target = tgt;
        @(posedge clk);
        if (reset_n) model_edge();
        #1;
    endtask

    // Asynchronous reset: outputs must clear without any clock edge
    task automatic do_reset();
        chk_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        check("rst_valid", 64'(Fetch_Valid), 64'd0);
        check("rst_count", 64'(Fetch_Count), 64'd0);
        check("rst_inst", 64'(Fetch_Inst), 64'd0);
        check("rst_pc", Fetch_PC, 64'd0);
        check("rst_error", 64'(Fetch_Error), 64'd0);
        check("rst_addr", Inst_Address, 64'd0);
        exp_q.delete();
        m_pc     = 64'd0;
        m_err    = 1'b0;
        @(posedge clk);
        #1;
        pop_seen = 1'b0;
        reset_n  = 1'b1;
        chk_en   = 1'b1;
    endtask

    function automatic logic [63:0] rand_target();
        int r;
        r = int'($urandom_range(0, 7));
        if (r == 0) return 64'($urandom_range(0, 70));
        if (r == 1) return 64'($urandom_range(16, 20)) << 2;
        return 64'($urandom_range(0, 15)) << 2;
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) imem[i] = $urandom;
        imem[0] = 32'h00D6_0533;
        imem[1] = 32'h00C5_0433;
        imem[2] = 32'h00A4_00B3;
        tests         = 0;
        fails         = 0;
        chk_en        = 1'b0;
        pop_seen      = 1'b0;
        reset_n       = 1'b1;
        Fetch_Enable  = 1'b0;
        Fetch_Ready   = 1'b0;
        Branch_Taken  = 1'b0;
        Branch_Target = '0;
        #3;
        do_reset();

        // Straight-line fetch from reset
        repeat (6) step(1, 1, 0, 0);

        // Decode stalled from the start, then released
        do_reset();
        repeat (5) step(1, 0, 0, 0);
        check("stall_count", 64'(Fetch_Count), 64'd2);
        check("stall_addr", Inst_Address, 64'd8);
        check("stall_inst", 64'(Fetch_Inst), 64'h00D6_0533);
        repeat (6) step(1, 1, 0, 0);

        // Branch while full, with a same-cycle pop request that must be discarded
        do_reset();
        repeat (3) step(1, 0, 0, 0);
        step(1, 1, 1, 64'd0);
        check("br_valid", 64'(Fetch_Valid), 64'd0);
        check("br_count", 64'(Fetch_Count), 64'd0);
        check("br_addr", Inst_Address, 64'd0);
        repeat (3) step(1, 1, 0, 0);

        // Misaligned target raises a sticky error that a later branch does not clear
        step(1, 1, 1, 64'd6);
        repeat (3) step(1, 1, 0, 0);
        step(1, 1, 1, 64'd0);
        repeat (3) step(1, 1, 0, 0);
        check("sticky_err", 64'(Fetch_Error), 64'd1);

        // Run off the end of memory
        do_reset();
        repeat (20) step(1, 1, 0, 0);
        check("end_err", 64'(Fetch_Error), 64'd1);
        check("end_addr", Inst_Address, 64'd64);

        // Reset mid-stream with a full buffer
        do_reset();
        repeat (2) step(1, 0, 0, 0);
        check("pre_rst_count", 64'(Fetch_Count), 64'd2);
        do_reset();
        repeat (4) step(1, 1, 0, 0);

        // Randomized traffic
        for (int c = 0; c < 30; c++) begin
            do_reset();
            for (int k = 0; k < 40; k++) begin
                step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                     ($urandom_range(0, 9) == 0), rand_target());
            end
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
